// File: rtl/pc_trace_unit.sv
// pc_trace_unit: circular PC trace buffer plus pass/fail result register on the data bus.
// Optional TRACE_DEDUP_EN drops a retired PC equal to the last stored one (self-loop spin).
module pc_trace_unit #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        sysClk,
  input  logic        sysResN,
  input  logic        pcValid,
  input  logic [31:0] pc,
  input  logic        busEn,
  input  logic        busWe,
  input  logic [3:0]  busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        busRValid,
  output logic        halted,
  output logic        pass,
  output logic        fail
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_idx, rd_pos;
  logic [PTR_W:0] count;
  logic wrapped;
  logic [31:0] fail_code, status, rdata;
  logic [1:0] sel;
  logic rd, wr, cap, data_hit, tohost_set, unused_ok;
  assign sel = busAddr[3:2];
  assign unused_ok = ^busAddr[1:0];
  assign rd = busEn & ~busWe;
  assign wr = busEn & busWe;
`ifdef TRACE_DEDUP_EN
  logic [31:0] last_pc;
  logic last_pc_valid;
  assign cap = pcValid & ~halted & ~(last_pc_valid & (pc == last_pc));
  always_ff @(posedge sysClk or negedge sysResN)
    if (!sysResN) begin
      last_pc <= '0;
      last_pc_valid <= 1'b0;
    end else if (cap) begin
      last_pc <= pc;
      last_pc_valid <= 1'b1;
    end
`else
  assign cap = pcValid & ~halted;
`endif
  // oldest entry sits count slots behind the write pointer
  assign rd_pos = wr_ptr - count[PTR_W-1:0] + rd_idx;
  assign data_hit = {1'b0, rd_idx} < count;
  assign tohost_set = wr && sel == 2'd1 && !halted && busWData != '0;
  assign status = {16'b0, 8'(count), 4'b0, wrapped, fail, pass, halted};
  assign rdata = sel == 2'd0 ? status :
                 sel == 2'd1 ? fail_code :
                 sel == 2'd2 ? 32'(rd_idx) :
                 data_hit ? mem[rd_pos] : '0;
  always_ff @(posedge sysClk)
    if (cap) mem[wr_ptr] <= pc;
  always_ff @(posedge sysClk or negedge sysResN)
    if (!sysResN) begin
      wr_ptr <= '0;
      count <= '0;
      rd_idx <= '0;
      wrapped <= 1'b0;
      busRData <= '0;
      busRValid <= 1'b0;
      halted <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      fail_code <= '0;
    end else begin
      busRValid <= rd;
      if (rd) busRData <= rdata;
      if (cap) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count == FULL) wrapped <= 1'b1;
        else count <= count + 1'b1;
      end
      if (rd && sel == 2'd3 && data_hit) rd_idx <= rd_idx + 1'b1;
      else if (wr && sel == 2'd2) rd_idx <= busWData[PTR_W-1:0];
      if (tohost_set) begin
        halted <= 1'b1;
        pass <= busWData == 32'd1;
        fail <= busWData != 32'd1;
        if (busWData != 32'd1) fail_code <= busWData;
      end
    end
endmodule

// File: tb/tb_pc_trace_unit.sv
// tb_pc_trace_unit: randomized and directed checks of pc_trace_unit against a queue-based trace model.
module tb_pc_trace_unit;
  localparam int DEPTH = 16;
  logic sysClk = 0, sysResN = 0, pcValid = 0, busEn = 0, busWe = 0;
  logic [31:0] pc = 0, busWData = 0;
  logic [3:0] busAddr = 0;
  logic [31:0] busRData;
  logic busRValid, halted, pass, fail;
  int n_cmp = 0, n_bad = 0;

  pc_trace_unit #(.DEPTH(DEPTH)) dut (
    .sysClk(sysClk), .sysResN(sysResN), .pcValid(pcValid), .pc(pc),
    .busEn(busEn), .busWe(busWe), .busAddr(busAddr), .busWData(busWData),
    .busRData(busRData), .busRValid(busRValid),
    .halted(halted), .pass(pass), .fail(fail)
  );

  always #5 sysClk = ~sysClk;

  logic [31:0] m_q[$];
  bit m_wrapped, m_halted, m_pass, m_fail;
  logic [31:0] m_code;
  int m_rd;
  logic [31:0] m_last;
  bit m_last_v;

  function automatic void m_reset();
    m_q.delete();
    m_wrapped = 0; m_halted = 0; m_pass = 0; m_fail = 0;
    m_code = 0; m_rd = 0; m_last = 0; m_last_v = 0;
  endfunction

  function automatic void m_capture(input logic [31:0] p);
    if (m_halted) return;
`ifdef TRACE_DEDUP_EN
    if (m_last_v && p == m_last) return;
    m_last = p;
    m_last_v = 1;
`endif
    m_q.push_back(p);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_wrapped = 1;
    end
  endfunction

  function automatic void m_tohost(input logic [31:0] d);
    if (m_halted || d == 0) return;
    m_halted = 1;
    if (d == 1) m_pass = 1;
    else begin
      m_fail = 1;
      m_code = d;
    end
  endfunction

  function automatic logic [31:0] m_status();
    logic [7:0] c;
    c = 8'(m_q.size());
    return {16'b0, c, 4'b0, m_wrapped, m_fail, m_pass, m_halted};
  endfunction

  function automatic logic [31:0] m_data();
    logic [31:0] r;
    r = 0;
    if (m_rd < m_q.size()) begin
      r = m_q[m_rd];
      m_rd = (m_rd + 1) % DEPTH;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic do_reset();
    pcValid = 0; busEn = 0; busWe = 0;
    sysResN = 0;
    #7;
    sysResN = 1;
    m_reset();
    tick();
  endtask

  // One bus/retire cycle; exp is the model's read data for a read, using pre-update state.
  task automatic cycle(input bit pv, input logic [31:0] p, input bit en, input bit we,
                       input logic [1:0] a, input logic [31:0] wd, output logic [31:0] exp);
    exp = 'x;
    if (en && !we)
      exp = a == 0 ? m_status() : a == 1 ? m_code : a == 2 ? 32'(m_rd) : m_data();
    pcValid = pv; pc = p; busEn = en; busWe = we; busAddr = {a, 2'b00}; busWData = wd;
    tick();
    if (pv) m_capture(p);
    if (en && we) begin
      if (a == 1) m_tohost(wd);
      else if (a == 2) m_rd = int'(wd % DEPTH);
    end
    pcValid = 0; busEn = 0; busWe = 0;
  endtask

  task automatic strobe(input logic [31:0] p);
    logic [31:0] e;
    cycle(1, p, 0, 0, 0, 0, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] e;
    cycle(0, 0, 1, 1, a, d, e);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] e);
    cycle(0, 0, 1, 0, a, 0, e);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    do_reset();
    n_cmp++;
    if ({busRValid, halted, pass, fail, busRData} !== 36'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b/%h want 0/0", {busRValid, halted, pass, fail}, busRData);
    end
    rd(0, e);
    n_cmp++;
    if (busRData !== 32'h0 || busRValid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_status: got %h v=%b want 00000000 v=1", busRData, busRValid);
    end
    rd(2, e);
    n_cmp++;
    if (busRData !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdidx: got %h want 0", busRData);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) strobe(32'(4 * i));
    rd(0, e);
    n_cmp++;
    if (busRData !== 32'h0000_0500) begin
      n_bad++;
      $display("FAIL basic_status: got %h want 00000500", busRData);
    end
    wr(2, 0);
    for (int i = 0; i < 6; i++) begin
      rd(3, e);
      n_cmp++;
      if (busRValid !== 1'b1 || busRData !== e) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: got %h v=%b want %h v=1", i, busRData, busRValid, e);
      end
    end
    rd(2, e);
    n_cmp++;
    if (busRData !== 32'd5) begin
      n_bad++;
      $display("FAIL basic_rdidx_stuck: got %h want 5", busRData);
    end
    tick();
    n_cmp++;
    if (busRValid !== 1'b0 || busRData !== 32'd5) begin
      n_bad++;
      $display("FAIL basic_hold: got %h v=%b want 00000005 v=0", busRData, busRValid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 20; i++) strobe(32'(4 * i));
    rd(0, e);
    n_cmp++;
    if (busRData !== 32'h0000_1008) begin
      n_bad++;
      $display("FAIL wrap_status: got %h want 00001008", busRData);
    end
    wr(2, 0);
    for (int i = 0; i < 16; i++) begin
      rd(3, e);
      n_cmp++;
      if (busRData !== 32'(16 + 4 * i)) begin
        n_bad++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, busRData, 32'(16 + 4 * i));
      end
    end
  endtask

  task automatic test_pass();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) strobe(32'h100 + 32'(4 * i));
    wr(1, 1);
    n_cmp++;
    if ({halted, pass, fail} !== 3'b110) begin
      n_bad++;
      $display("FAIL pass_flags: got %b want 110", {halted, pass, fail});
    end
    strobe(32'h200);
    strobe(32'h204);
    rd(0, e);
    n_cmp++;
    if (busRData !== e) begin
      n_bad++;
      $display("FAIL pass_frozen_status: got %h want %h", busRData, e);
    end
    wr(1, 7);
    rd(1, e);
    n_cmp++;
    if (busRData !== 32'h0 || fail !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_sticky: got code %h fail=%b want 0 fail=0", busRData, fail);
    end
  endtask

  task automatic test_fail_same_cycle();
    logic [31:0] e;
    do_reset();
    strobe(32'h7C);
    wr(1, 0);
    n_cmp++;
    if (halted !== 1'b0) begin
      n_bad++;
      $display("FAIL fail_zero_write: got halted=%b want 0", halted);
    end
    cycle(1, 32'h80, 1, 1, 1, 32'h2A, e);
    n_cmp++;
    if ({halted, pass, fail} !== 3'b101) begin
      n_bad++;
      $display("FAIL fail_flags: got %b want 101", {halted, pass, fail});
    end
    rd(1, e);
    n_cmp++;
    if (busRData !== 32'h2A) begin
      n_bad++;
      $display("FAIL fail_code: got %h want 0000002a", busRData);
    end
    wr(2, 1);
    rd(3, e);
    n_cmp++;
    if (busRData !== 32'h80) begin
      n_bad++;
      $display("FAIL fail_pc_captured: got %h want 00000080", busRData);
    end
    rd(0, e);
    n_cmp++;
    if (busRData !== e) begin
      n_bad++;
      $display("FAIL fail_status: got %h want %h", busRData, e);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) strobe(32'h40 + 32'(i));
    wr(1, 5);
    busEn = 1; busWe = 0; busAddr = 4'h4;
    tick();
    busEn = 0;
    #2;
    sysResN = 0;
    #1;
    n_cmp++;
    if ({busRValid, halted, pass, fail, busRData} !== 36'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b/%h want 0/0", {busRValid, halted, pass, fail}, busRData);
    end
    #3;
    sysResN = 1;
    m_reset();
    tick();
    rd(0, e);
    n_cmp++;
    if (busRData !== 32'h0) begin
      n_bad++;
      $display("FAIL async_status: got %h want 0", busRData);
    end
    rd(3, e);
    n_cmp++;
    if (busRData !== 32'h0) begin
      n_bad++;
      $display("FAIL async_data: got %h want 0", busRData);
    end
  endtask

  task automatic test_dedup();
    logic [31:0] e;
    do_reset();
    strobe(32'hA4); strobe(32'hA4); strobe(32'hA4); strobe(32'hA8);
    rd(0, e);
    n_cmp++;
`ifdef TRACE_DEDUP_EN
    if (busRData[15:8] !== 8'd2) begin
      n_bad++;
      $display("FAIL dedup_count: got %0d want 2", busRData[15:8]);
    end
`else
    if (busRData[15:8] !== 8'd4) begin
      n_bad++;
      $display("FAIL dedup_count: got %0d want 4", busRData[15:8]);
    end
`endif
    wr(2, 0);
    for (int i = 0; i < 4; i++) begin
      rd(3, e);
      n_cmp++;
      if (busRData !== e) begin
        n_bad++;
        $display("FAIL dedup_data[%0d]: got %h want %h", i, busRData, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bit pv;
    do_reset();
    for (int i = 0; i < 10; i++) strobe(32'h1000 + 32'(8 * i));
    wr(2, 0);
    for (int i = 0; i < 14; i++) begin
      pv = 1'($urandom_range(0, 1));
      cycle(pv, $urandom, 1, 0, 3, 0, e);
      n_cmp++;
      if (busRValid !== 1'b1 || busRData !== e) begin
        n_bad++;
        $display("FAIL b2b_data[%0d]: got %h v=%b want %h v=1", i, busRData, busRValid, e);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e, p;
    int op;
    bit pv;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      pv = 1'($urandom_range(0, 1));
      p = 32'($urandom_range(0, 7)) << 2;
      if (op < 5) cycle(1, p, 0, 0, 0, 0, e);
      else if (op < 8) begin
        cycle(pv, p, 1, 0, 2'($urandom_range(0, 3)), 0, e);
        n_cmp++;
        if (busRValid !== 1'b1 || busRData !== e) begin
          n_bad++;
          $display("FAIL rand_read[%0d]: got %h v=%b want %h v=1", i, busRData, busRValid, e);
        end
      end else if (op == 8) cycle(pv, p, 1, 1, 2'd2, $urandom, e);
      else if (i > 200) cycle(pv, p, 1, 1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), e);
      else cycle(pv, p, 1, 1, 2'd3, $urandom, e);
    end
    n_cmp++;
    if ({halted, pass, fail} !== {m_halted, m_pass, m_fail}) begin
      n_bad++;
      $display("FAIL rand_flags: got %b want %b", {halted, pass, fail}, {m_halted, m_pass, m_fail});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_pass();
    test_fail_same_cycle();
    test_async_reset();
    test_dedup();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
